scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Registered 3-bit channel-index generator that drives the 3-to-8 one-hot decoder stage directly downstream. Steps its select output through 0..7 (up or down) at a programmable dwell rate, with continuous or single-sweep modes and a synchronous preload. It also emits per-step and wrap strobes, so the decoder's one-hot output becomes a timed channel scan.

## Interface
- DWELL_W, default 8: width of the dwell counter and of the `dwell` input.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable. 0 freezes the scan and returns the FSM to IDLE.
- mode  input  1  0 = continuous scan, 1 = single sweep (stops after one wrap).
- dir  input  1  0 = count up (7→0 wraps), 1 = count down (0→7 wraps).
- dwell  input  DWELL_W  cycles per step minus one. 0 means advance every cycle.
- load  input  1  synchronous preload strobe.
- load_val  input  3  value copied into `sel` on `load`.
- sel  output  3  current channel index. Registered; feeds the decoder input.
- tick  output  1  one-cycle pulse in the first cycle a new `sel` is visible from a step.
- wrap  output  1  one-cycle pulse coincident with `tick` when the step wrapped.
- done  output  1  single-sweep complete. Held until `en` = 0 or `load`.
- busy  output  1  high while FSM is in RUN.

## Operation
- FSM states:
  - IDLE: waiting for `en`.
  - RUN: dwell counting and stepping.
  - DONE: single sweep finished.
- Transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0.
  - RUN→DONE on a wrapping step with `mode`=1.
  - DONE→IDLE when `en`=0.
  - Any state→IDLE on `rst`.
- Dwell counter `cnt` (DWELL_W bits), cleared in IDLE and DONE.
  - In RUN, if `cnt` >= `dwell`: step `sel`, clear `cnt`.
  - Otherwise `cnt` increments.
  - The comparison is >=, so reducing `dwell` mid-count below `cnt` forces a step on the next cycle.
- Step arithmetic is modulo 8.
  - Up: sel+1; 7→0 wraps.
  - Down: sel−1; 0→7 wraps.
  - `dir` is sampled at the step cycle only.
- `load` has priority over stepping in every state except reset:
  - `sel` ← `load_val` and `cnt` ← 0.
  - No `tick` or `wrap` is generated.
  - From DONE, `load` clears `done` and goes to RUN if `en`=1, else IDLE.
- `mode` is sampled at each wrapping step. Changing it mid-sweep affects only the next wrap.
- In single-sweep mode the wrapping step still updates `sel`. `sel` then holds that value (0 for up, 7 for down) in DONE.
- While `en`=0, `sel` holds its value. Re-enabling resumes from the held `sel` with `cnt`=0.
- `busy` = (state == RUN). `done` = (state == DONE).

## Timing
- Reset values: sel=0, tick=0, wrap=0, done=0, busy=0, cnt=0, state=IDLE.
- `rst` overrides `load` and `en` in the same cycle.
- `en` rising at edge N: `busy`=1 after edge N. Counting starts at edge N+1.
- With dwell=D, consecutive steps are exactly D+1 cycles apart.
  - The first step after entering RUN occurs D+1 edges after entry.
- `tick` and `wrap` are registered outputs, high for exactly one cycle, aligned with the new `sel`.
- `load` at edge N: `sel`=load_val after edge N. The next step is D+1 edges later if in RUN.
- `en` falling while in RUN: no step occurs at that edge, even if `cnt` >= `dwell`.
- Simultaneous `load` and step-due: load wins, no tick.
- Simultaneous `en`=0 and `load`: load applied, state → IDLE.

## Test plan
- Reset then en=1, mode=0, dir=0, dwell=0: sel = 0,1,2…7,0 on successive cycles; tick every cycle; wrap only on the 7→0 cycle; busy=1, done=0.
- dwell=3, continuous up from 0: sel changes every 4 cycles; 8 steps take 32 cycles; wrap once per 32 cycles.
- mode=1, dir=1, dwell=1, load_val=3 with load then en=1: sel 3,2,1,0,7; done=1 and busy=0 after the 0→7 step; sel holds 7 for 10 more cycles with no tick.
- Mid-run load: at sel=5 with dwell=2, assert load with load_val=1 in the cycle a step is due: sel=1, tick=0, next tick 3 cycles later with sel=2.
- Dwell shrink: dwell=10 with cnt at 6, change dwell to 2: step on the next cycle, then every 3 cycles.
- Reset mid-run with load also asserted at sel=6: all outputs at reset values next cycle (sel=0, busy=0, tick=0).

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Bundles the scan sequencer's control inputs and its scan outputs.
// The master modport drives the controls; the slave modport is the sequencer itself.
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
) ();
    logic               en;
    logic               mode;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic               load;
    logic [2:0]         load_val;
    logic [2:0]         sel;
    logic               tick;
    logic               wrap;
    logic               done;
    logic               busy;

    modport master (
        output en, mode, dir, dwell, load, load_val,
        input  sel, tick, wrap, done, busy
    );

    modport slave (
        input  en, mode, dir, dwell, load, load_val,
        output sel, tick, wrap, done, busy
    );
endinterface

// File: rtl/scan_sequencer.sv
// Registered 3-bit channel-index generator for the downstream 3-to-8 decoder:
// steps sel up or down at a programmable dwell rate, continuous or single sweep.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for en; sel held, dwell counter clear
// S_RUN  | dwell counting and stepping sel
// S_DONE | single sweep finished; sel held at wrap value
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    scan_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;

    logic [2:0]         sel_step;
    logic               step_wraps;
    logic               step_due;

    // dir only matters at the step cycle, so the step value is formed combinationally.
    always_comb begin
        if (bus.dir) begin
            sel_step   = sel_q - 3'd1;
            step_wraps = (sel_q == 3'd0);
        end else begin
            sel_step   = sel_q + 3'd1;
            step_wraps = (sel_q == 3'd7);
        end
    end

    // >= rather than == so that shrinking dwell below cnt forces a prompt step.
    assign step_due = (cnt_q >= bus.dwell);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.load) begin
                    sel_d = bus.load_val;
                end
                if (bus.en) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (bus.load) begin
                        sel_d = bus.load_val;
                    end
                end else if (bus.load) begin
                    sel_d = bus.load_val;
                    cnt_d = '0;
                end else if (step_due) begin
                    sel_d  = sel_step;
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    wrap_d = step_wraps;
                    if (step_wraps && bus.mode) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                cnt_d = '0;
                if (bus.load) begin
                    sel_d   = bus.load_val;
                    state_d = bus.en ? S_RUN : S_IDLE;
                end else if (!bus.en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: expected steps are queued with the edge they
// must appear on, and a negedge monitor pops and compares on every tick.
module tb_scan_sequencer;

    localparam int DWELL_W = 8;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       wrap;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    scan_sequencer_if #(.DWELL_W(DWELL_W)) sif ();

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int s, input bit w, input bit d);
        exp_t e;
        e.cyc  = c;
        e.sel  = 3'(s);
        e.wrap = w;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every tick must match the oldest queued expectation exactly.
    always @(negedge clk) begin
        exp_t e;
        if (sif.wrap && !sif.tick) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL wrap_without_tick: wrap=1 tick=0 at edge %0d", cyc);
        end
        if (sif.tick) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_tick: sel=%0d at edge %0d, none expected", sif.sel, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || sif.sel != e.sel || sif.wrap != e.wrap ||
                    sif.done != e.done || sif.busy != !e.done) begin
                    failures = failures + 1;
                    $display("FAIL step: got edge=%0d sel=%0d wrap=%0d done=%0d busy=%0d expected edge=%0d sel=%0d wrap=%0d done=%0d busy=%0d",
                             cyc, sif.sel, sif.wrap, sif.done, sif.busy,
                             e.cyc, e.sel, e.wrap, e.done, !e.done);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        sif.en       = 1'b0;
        sif.mode     = 1'b0;
        sif.dir      = 1'b0;
        sif.dwell    = '0;
        sif.load     = 1'b0;
        sif.load_val = 3'd0;

        repeat (3) @(negedge clk);
        chk("reset_sel",  sif.sel,  0);
        chk("reset_tick", sif.tick, 0);
        chk("reset_wrap", sif.wrap, 0);
        chk("reset_done", sif.done, 0);
        chk("reset_busy", sif.busy, 0);

        // Continuous up, dwell 0: one step per cycle, wrap on 7->0.
        rst     = 1'b0;
        sif.en  = 1'b1;
        n = cyc + 1;
        push(n+1, 1, 0, 0); push(n+2, 2, 0, 0); push(n+3, 3, 0, 0); push(n+4, 4, 0, 0);
        push(n+5, 5, 0, 0); push(n+6, 6, 0, 0); push(n+7, 7, 0, 0); push(n+8, 0, 1, 0);
        wait_cyc(n);
        chk("run_busy", sif.busy, 1);
        chk("run_done", sif.done, 0);
        chk("run_sel_before_first_step", sif.sel, 0);
        wait_cyc(n+8);
        sif.en = 1'b0;
        wait_cyc(n+10);
        chk("idle_busy", sif.busy, 0);
        chk("idle_sel_held", sif.sel, 0);

        // Continuous up, dwell 3: steps every 4 cycles, one wrap per 32.
        sif.en    = 1'b1;
        sif.dwell = 8'd3;
        n = cyc + 1;
        push(n+4, 1, 0, 0);  push(n+8, 2, 0, 0);  push(n+12, 3, 0, 0); push(n+16, 4, 0, 0);
        push(n+20, 5, 0, 0); push(n+24, 6, 0, 0); push(n+28, 7, 0, 0); push(n+32, 0, 1, 0);
        wait_cyc(n+32);
        sif.en = 1'b0;
        wait_cyc(n+34);

        // Single sweep down from a preload of 3, dwell 1.
        sif.load     = 1'b1;
        sif.load_val = 3'd3;
        sif.mode     = 1'b1;
        sif.dir      = 1'b1;
        sif.dwell    = 8'd1;
        @(negedge clk);
        chk("load_idle_sel", sif.sel, 3);
        chk("load_idle_tick", sif.tick, 0);
        sif.load = 1'b0;
        sif.en   = 1'b1;
        n = cyc + 1;
        push(n+2, 2, 0, 0); push(n+4, 1, 0, 0); push(n+6, 0, 0, 0); push(n+8, 7, 1, 1);
        wait_cyc(n+18);
        chk("sweep_hold_sel", sif.sel, 7);
        chk("sweep_done", sif.done, 1);
        chk("sweep_busy", sif.busy, 0);
        sif.en = 1'b0;
        @(negedge clk);
        chk("done_cleared_by_en", sif.done, 0);
        sif.mode = 1'b0;
        sif.dir  = 1'b0;

        // Load collides with a due step: load wins, no tick, dwell restarts.
        sif.load     = 1'b1;
        sif.load_val = 3'd4;
        @(negedge clk);
        sif.load  = 1'b0;
        sif.en    = 1'b1;
        sif.dwell = 8'd2;
        n = cyc + 1;
        push(n+3, 5, 0, 0); push(n+9, 2, 0, 0);
        wait_cyc(n+5);
        sif.load     = 1'b1;
        sif.load_val = 3'd1;
        wait_cyc(n+6);
        sif.load = 1'b0;
        chk("midrun_load_sel", sif.sel, 1);
        chk("midrun_load_tick", sif.tick, 0);
        wait_cyc(n+9);
        sif.en = 1'b0;
        wait_cyc(n+10);

        // Dwell shrinks below the running count: immediate step, then every 3.
        sif.en    = 1'b1;
        sif.dwell = 8'd10;
        n = cyc + 1;
        wait_cyc(n+6);
        sif.dwell = 8'd2;
        push(n+7, 3, 0, 0); push(n+10, 4, 0, 0); push(n+13, 5, 0, 0);
        wait_cyc(n+13);
        sif.en = 1'b0;
        wait_cyc(n+14);

        // Reset together with load mid-run: reset wins.
        sif.en    = 1'b1;
        sif.dwell = 8'd0;
        n = cyc + 1;
        push(n+1, 6, 0, 0);
        wait_cyc(n+1);
        rst          = 1'b1;
        sif.load     = 1'b1;
        sif.load_val = 3'd3;
        wait_cyc(n+2);
        chk("rst_over_load_sel",  sif.sel,  0);
        chk("rst_over_load_busy", sif.busy, 0);
        chk("rst_over_load_tick", sif.tick, 0);
        chk("rst_over_load_wrap", sif.wrap, 0);
        chk("rst_over_load_done", sif.done, 0);
        rst      = 1'b0;
        sif.load = 1'b0;
        sif.en   = 1'b0;
        repeat (3) @(negedge clk);
        chk("expected_steps_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
